// File: rtl/mdu_sequencer_pkg.sv
// Shared RV32M defines: funct3 encodings of the MDU ops, sequencer state encoding
// and the number of iterative steps per multiply/divide.
package mdu_sequencer_pkg;

    localparam int MDU_ITER = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// Iterative MDU arithmetic on operand magnitudes: one shift-add or one restoring
// subtract-shift step per cycle into a 2*XLEN accumulator. Divide step only with SAIL_MDU_DIV_EN.
module mdu_datapath
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
`ifdef SAIL_MDU_DIV_EN
    input  logic              i_is_div,
`endif
    input  logic              i_load,
    input  logic              i_step,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_acc
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_mul_nxt;

    // Multiply: {hi, lo} with lo holding the unconsumed multiplier bits.
    assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
    assign w_mul_nxt = r_acc[0] ? {w_add, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

`ifdef SAIL_MDU_DIV_EN
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_nxt;

    // Divide: {remainder, quotient}; the true difference always fits XLEN bits when w_ge.
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge      = w_rem_sh >= {1'b0, r_b};
    assign w_diff    = w_rem_sh[XLEN-1:0] - r_b;
    assign w_div_nxt = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};
`endif

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_acc <= {{XLEN{1'b0}}, i_a};
            r_b   <= i_b;
        end else if (i_step) begin
`ifdef SAIL_MDU_DIV_EN
            r_acc <= i_is_div ? w_div_nxt : w_mul_nxt;
`else
            r_acc <= w_mul_nxt;
`endif
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: FSM, step counter, request/response handshake and sign fixup.
// Divide ops (funct3 1xx) are only implemented when SAIL_MDU_DIV_EN is defined.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o,
    output logic            busy_o,
    output mdu_state_e      dbg_state_o
);

    localparam int            CW        = $clog2(MDU_ITER);
    localparam logic [CW-1:0] LAST_STEP = CW'(MDU_ITER - 1);

    mdu_state_e        r_state;
    mdu_state_e        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_funct3;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;
    logic              r_illegal;

    logic              w_accept;
    logic              w_step;
    logic              w_short;
    logic              w_short_illegal;
    logic [XLEN-1:0]   w_short_result;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [2*XLEN-1:0] w_acc;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_fix_result;

    // Handshake: a request transfers on a cycle with req_valid_i & req_ready_o (IDLE only);
    // a response transfers on resp_valid_o & resp_ready_i and the FSM is back in IDLE a cycle later.
    assign w_accept = req_valid_i && (r_state == ST_IDLE) && !reset_i;
    assign w_step   = (r_state == ST_CALC);

`ifdef SAIL_MDU_DIV_EN
    assign w_short         = funct3_i[2] && (rs2_i == '0);
    assign w_short_illegal = 1'b0;
    assign w_short_result  = funct3_i[1] ? rs1_i : '1;
`else
    assign w_short         = funct3_i[2];
    assign w_short_illegal = 1'b1;
    assign w_short_result  = '0;
`endif

    assign w_a_neg = rs1_i[XLEN-1] && (funct3_i == F3_MULH || funct3_i == F3_MULHSU ||
                                       funct3_i == F3_DIV  || funct3_i == F3_REM);
    assign w_b_neg = rs2_i[XLEN-1] && (funct3_i == F3_MULH || funct3_i == F3_DIV ||
                                       funct3_i == F3_REM);
    assign w_a_mag = w_a_neg ? -rs1_i : rs1_i;
    assign w_b_mag = w_b_neg ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; products and quotients the xor of both.
    assign w_neg   = (funct3_i[2] && funct3_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    mdu_datapath #(.XLEN(XLEN)) u_datapath (
        .i_clk    (clk_i),
`ifdef SAIL_MDU_DIV_EN
        .i_is_div (r_funct3[2]),
`endif
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_a      (w_a_mag),
        .i_b      (w_b_mag),
        .o_acc    (w_acc)
    );

    assign w_prod = r_neg ? -w_acc : w_acc;

`ifdef SAIL_MDU_DIV_EN
    logic [XLEN-1:0] w_word;
    assign w_word       = r_funct3[1] ? w_acc[2*XLEN-1:XLEN] : w_acc[XLEN-1:0];
    assign w_fix_result = r_funct3[2] ? (r_neg ? -w_word : w_word) :
                          (r_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`else
    assign w_fix_result = (r_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_neg     <= 1'b0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt     <= '0;
                r_funct3  <= funct3_i;
                r_neg     <= w_neg;
                r_result  <= w_short_result;
                r_illegal <= w_short_illegal;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_FIXUP) begin
                r_result  <= w_fix_result;
                r_illegal <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        result_o     = '0;
        illegal_o    = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = !reset_i;
                if (w_accept) w_state_nxt = w_short ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                busy_o = !reset_i;
                if (r_cnt == LAST_STEP) w_state_nxt = ST_FIXUP;
            end
            ST_FIXUP: begin
                busy_o      = !reset_i;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy_o       = !reset_i;
                resp_valid_o = !reset_i;
                result_o     = reset_i ? '0 : r_result;
                illegal_o    = !reset_i && r_illegal;
                if (resp_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: vector table of ops with hand-computed results and
// latencies, plus backpressure and mid-operation reset sequences.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] result_o;
    logic        illegal_o;
    logic        busy_o;
    mdu_state_e  dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    mdu_sequencer #(.XLEN(32)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .funct3_i     (funct3_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o),
        .illegal_o    (illegal_o),
        .busy_o       (busy_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] r, input logic ill,
                           input int lat);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.r = r; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Entered and left #1 after a rising edge. hold = cycles to stall in DONE before acking.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_i,
                          input int exp_lat, input int hold);
        int lat;
        req_valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
        @(negedge clk);
        check({name, " req_ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (resp_valid_o) break;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result_o, exp_r);
        check({name, " illegal"}, 32'(illegal_o), 32'(exp_i));
        check({name, " ready_in_done"}, 32'(req_ready_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check({name, " hold_valid"}, 32'(resp_valid_o), 32'd1);
            check({name, " hold_result"}, result_o, exp_r);
            check({name, " hold_ready"}, 32'(req_ready_o), 32'd0);
            check({name, " hold_busy"}, 32'(busy_o), 32'd1);
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        @(negedge clk);
        check({name, " idle_state"}, 32'(dbg_state_o), 32'(ST_IDLE));
        check({name, " idle_valid"}, 32'(resp_valid_o), 32'd0);
        check({name, " idle_result"}, result_o, 32'd0);
        check({name, " idle_busy"}, 32'(busy_o), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        add_vec("mul_7_m3",      F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34);
        add_vec("mulhu_max",     F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
        add_vec("mulhsu_m1",     F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34);
        add_vec("mulh_m1_m1",    F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34);
        add_vec("mulh_min_min",  F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34);
        add_vec("mulh_7_m3",     F3_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
        add_vec("mul_2p16_sq",   F3_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 34);
        add_vec("mulhu_2p16_sq", F3_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 34);
`ifdef SAIL_MDU_DIV_EN
        add_vec("div_m7_2",      F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34);
        add_vec("rem_m7_2",      F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34);
        add_vec("divu_100_0",    F3_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1);
        add_vec("rem_5_0",       F3_REM,    32'd5,        32'd0,        32'd5,        1'b0, 1);
        add_vec("rem_ovf",       F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34);
        add_vec("div_ovf",       F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34);
        add_vec("divu_100_7",    F3_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 34);
        add_vec("remu_100_7",    F3_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 34);
`else
        add_vec("div_illegal",   F3_DIV,    32'hFFFFFFF9, 32'd2,        32'h00000000, 1'b1, 1);
        add_vec("remu_illegal",  F3_REMU,   32'd100,      32'd7,        32'h00000000, 1'b1, 1);
        add_vec("divu_z_illeg",  F3_DIVU,   32'd100,      32'd0,        32'h00000000, 1'b1, 1);
`endif

        reset_i = 1'b1; req_valid_i = 1'b1; funct3_i = F3_MUL;
        rs1_i = 32'd3; rs2_i = 32'd4; resp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_valid", 32'(resp_valid_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
        @(posedge clk); #1;
        reset_i = 1'b0; req_valid_i = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].ill,
                   vecs[i].lat, 0);

        run_op("backpressure", F3_MUL, 32'd1234, 32'd1000, 32'd1234000, 1'b0, 34, 5);

        // Reset while the counter sits at step 10.
        req_valid_i = 1'b1; funct3_i = F3_MULHU; rs1_i = 32'hFFFFFFFF; rs2_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset_i = 1'b1;
        @(negedge clk);
        check("midrst_was_calc", 32'(dbg_state_o), 32'(ST_CALC));
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("midrst_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        check("midrst_ready_back", 32'(req_ready_o), 32'd1);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (resp_valid_o) seen++;
            end
            check("midrst_no_resp", 32'(seen), 32'd0);
        end
        @(posedge clk); #1;
        run_op("after_rst", F3_MULHU, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 34, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid_i, input, 1, the requester presents an operation.
REQ-005 SHALL have port req_ready_o, output, 1, the block accepts an operation this cycle.
REQ-006 SHALL have port funct3_i, input, 3, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports rs1_i and rs2_i, input, XLEN each, the operands.
REQ-008 SHALL have port resp_valid_o, output, 1, the result is presented.
REQ-009 SHALL have port resp_ready_i, input, 1, the consumer takes the result.
REQ-010 SHALL have port result_o, output, XLEN, the result.
REQ-011 SHALL have port illegal_o, output, 1, the accepted op was unsupported; qualified by resp_valid_o.
REQ-012 SHALL have port busy_o, output, 1, high in every state except IDLE; used by the hazard unit for stalls.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-014 SHALL drive req_ready_o=1 only in IDLE; accept = req_valid_i & req_ready_o; operands and funct3 are latched on accept.
REQ-015 On accept SHALL go IDLE->CALC with the iteration counter at 0; internal iteration uses operand magnitudes per signedness (MULH both signed, MULHSU rs1 signed only, DIV/REM both signed).
REQ-016 In CALC SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle; after 32 steps (counter 31) SHALL go to FIXUP.
REQ-017 In FIXUP SHALL apply sign correction (two's-complement negate when the result sign is negative) and select the low/high product word, quotient or remainder, then go to DONE.
REQ-018 Latency: accept in cycle T SHALL give resp_valid_o=1 in cycle T+34.
REQ-019 Divide by zero SHALL skip CALC/FIXUP (IDLE->DONE, response at T+1): quotient 0xFFFFFFFF, remainder rs1.
REQ-020 Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0 at normal latency.
REQ-021 In DONE SHALL hold resp_valid_o, result_o and illegal_o stable until resp_ready_i=1, then go to IDLE the next cycle; no new accept is possible in the handshake cycle.
REQ-022 SHALL hold result_o=0 and illegal_o=0 whenever resp_valid_o=0.

Reset
REQ-023 reset_i=1 SHALL force IDLE, counter 0, resp_valid_o=0, result_o=0, illegal_o=0, busy_o=0, and req_ready_o=0 during the reset cycle.
REQ-024 Reset during CALC, FIXUP or DONE SHALL abandon the operation with no response ever produced for it.

Configuration
REQ-025 Macro SAIL_MDU_DIV_EN defined SHALL enable the divide datapath and funct3 100-111.
REQ-026 Without SAIL_MDU_DIV_EN, funct3[2]=1 SHALL go IDLE->DONE with illegal_o=1, result_o=0, response at T+1, and no divider logic synthesized.

Structure
REQ-027 The MDU funct3 encodings, state encoding and the constant 32 (iteration count) SHALL live in the shared rv32i defines package.
REQ-028 The arithmetic step (shift-add / subtract-shift, 64-bit accumulator) SHALL be one sub-module, mdu_datapath; mdu_sequencer holds the FSM, counter and handshake.

Verification
REQ-029 MUL rs1=7, rs2=-3 -> result 0xFFFFFFEB, resp_valid_o at T+34.
REQ-030 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF at T+1; REM 0x80000000/-1 -> 0.
REQ-032 Hold resp_ready_i=0 for 5 cycles in DONE -> result stable, req_ready_o=0 throughout; on handshake, IDLE the next cycle.
REQ-033 reset_i pulsed at CALC step 10 -> IDLE next cycle, no resp_valid_o; a following request completes correctly.
REQ-034 Build without SAIL_MDU_DIV_EN, issue DIV -> illegal_o=1, result 0 at T+1.
